// File: rtl/seq_ctrl_pkg.sv
// ============================================================================
// seq_ctrl_pkg : shared types and constants for the sequence-detector feeder
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_CNT_W  = 5;

    // Pattern recognised by the downstream detector (overlapping).
    localparam logic [5:0] PATTERN = 6'b101011;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : synchronous-clear up counter that saturates at all-ones
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_feed_ctrl.sv
// ============================================================================
// seq_feed_ctrl : serialises a test word MSB-first into the 101011 detector
//                 and counts its match flags. Option macro: FIRST_POS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_feed_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int IDX_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] data_in,
    input  logic              det_flag,
    output logic              ser_out,
    output logic              det_clr_n,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [IDX_W-1:0]  bit_idx
`ifdef FIRST_POS_EN
    ,
    output logic              first_vld,
    output logic [IDX_W-1:0]  first_pos
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    state_t            r_state;
    logic [WORD_W-1:0] r_shreg;
    logic              w_accept;
    logic              w_cnt_inc;

    assign w_accept  = (r_state == IDLE) && start;
    // Flags seen outside SHIFT belong to stale detector history and are dropped.
    assign w_cnt_inc = (r_state == SHIFT) && det_flag;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_accept),
        .inc   (w_cnt_inc),
        .q     (match_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            ser_out   <= 1'b0;
            det_clr_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_idx   <= '0;
`ifdef FIRST_POS_EN
            first_vld <= 1'b0;
            first_pos <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    det_clr_n <= 1'b1;
                    ser_out   <= 1'b0;
                    if (start) begin
                        r_shreg   <= data_in;
                        busy      <= 1'b1;
                        det_clr_n <= 1'b0;
                        r_state   <= CLEAR;
`ifdef FIRST_POS_EN
                        first_vld <= 1'b0;
                        first_pos <= '0;
`endif
                    end
                end

                CLEAR: begin
                    det_clr_n <= 1'b1;
                    ser_out   <= r_shreg[WORD_W-1];
                    r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
                    bit_idx   <= '0;
                    r_state   <= SHIFT;
                end

                SHIFT: begin
`ifdef FIRST_POS_EN
                    // bit_idx still names the bit that completed the match.
                    if (det_flag && !first_vld) begin
                        first_vld <= 1'b1;
                        first_pos <= bit_idx;
                    end
`endif
                    if (bit_idx < LAST_IDX) begin
                        bit_idx <= bit_idx + 1'b1;
                        ser_out <= r_shreg[WORD_W-1];
                        r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
                    end else begin
                        ser_out <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    ser_out   <= 1'b0;
                    det_clr_n <= 1'b1;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_feed_ctrl.sv
// ============================================================================
// tb_seq_feed_ctrl : scoreboard bench for seq_feed_ctrl with detector models
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_feed_ctrl;
    import seq_ctrl_pkg::*;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 5;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [WORD_W-1:0] data_in = '0;

    logic              det_flag, ser_out, det_clr_n, busy, done;
    logic [CNT_W-1:0]  match_cnt;
    logic [IDX_W-1:0]  bit_idx;

    logic              s_det_flag, s_ser_out, s_det_clr_n, s_busy, s_done;
    logic [0:0]        s_match_cnt;
    logic [IDX_W-1:0]  s_bit_idx;

`ifdef FIRST_POS_EN
    logic              first_vld, s_first_vld;
    logic [IDX_W-1:0]  first_pos, s_first_pos;
`endif

    seq_feed_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .det_flag  (det_flag),
        .ser_out   (ser_out),
        .det_clr_n (det_clr_n),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt),
        .bit_idx   (bit_idx)
`ifdef FIRST_POS_EN
        ,
        .first_vld (first_vld),
        .first_pos (first_pos)
`endif
    );

    // One-bit counter instance exercises saturation alongside the main DUT.
    seq_feed_ctrl #(.WORD_W(WORD_W), .CNT_W(1)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .det_flag  (s_det_flag),
        .ser_out   (s_ser_out),
        .det_clr_n (s_det_clr_n),
        .busy      (s_busy),
        .done      (s_done),
        .match_cnt (s_match_cnt),
        .bit_idx   (s_bit_idx)
`ifdef FIRST_POS_EN
        ,
        .first_vld (s_first_vld),
        .first_pos (s_first_pos)
`endif
    );

    always #5 clk = ~clk;

    // Detector models: falling-edge sampling, registered flag, async clear.
    logic [5:0] hist, s_hist;
    always @(negedge clk or negedge det_clr_n) begin
        if (!det_clr_n) begin
            hist     <= '0;
            det_flag <= 1'b0;
        end else begin
            hist     <= {hist[4:0], ser_out};
            det_flag <= ({hist[4:0], ser_out} == PATTERN);
        end
    end
    always @(negedge clk or negedge s_det_clr_n) begin
        if (!s_det_clr_n) begin
            s_hist     <= '0;
            s_det_flag <= 1'b0;
        end else begin
            s_hist     <= {s_hist[4:0], s_ser_out};
            s_det_flag <= ({s_hist[4:0], s_ser_out} == PATTERN);
        end
    end

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int     cnt;
        int     sat;
        int     fvld;
        int     fpos;
        longint due;
    } exp_t;
    exp_t sb[$];

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("match_cnt", match_cnt, e.cnt);
                chk("sat_match_cnt", s_match_cnt, e.sat);
                chk("busy_at_done", busy, 1);
`ifdef FIRST_POS_EN
                chk("first_vld", first_vld, e.fvld);
                chk("first_pos", first_pos, e.fpos);
`endif
            end
        end
    end

    task automatic push(input int cnt, input int sat, input int fvld, input int fpos,
                        input longint due);
        exp_t e;
        e.cnt = cnt; e.sat = sat; e.fvld = fvld; e.fpos = fpos; e.due = due;
        sb.push_back(e);
    endtask

    // Drive a one-cycle start; returns #1 after the accepting edge (CLEAR).
    task automatic launch(input logic [WORD_W-1:0] w, input int cnt, input int sat,
                          input int fvld, input int fpos);
        @(posedge clk); #1;
        data_in = w;
        start   = 1'b1;
        push(cnt, sat, fvld, fpos, cyc + 18);
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = 16'h5555;
        chk("clear_det_clr_n", det_clr_n, 0);
        chk("clear_busy", busy, 1);
        @(posedge clk); #1;
        chk("shift_det_clr_n", det_clr_n, 1);
    endtask

    task automatic finish_run();
        int n = 0;
        while (busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("run_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("done_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        longint c0;
        int n;

        #2;
        chk("rst_det_clr_n", det_clr_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ser_out", ser_out, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_bit_idx", bit_idx, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_det_clr_n", det_clr_n, 1);

        // Single match, completing at bit 5.
        launch(16'hAC00, 1, 1, 1, 5);
        finish_run();

        // Overlapping matches at bits 5 and 10; 1-bit counter saturates.
        launch(16'hAD60, 2, 1, 1, 5);
        finish_run();

        // All-ones word after a run: CLEAR must flush any leftover history.
        launch(16'hAC00, 1, 1, 1, 5);
        finish_run();
        launch(16'hFFFF, 0, 0, 0, 0);
        finish_run();

        // Start pulsed during SHIFT is ignored.
        launch(16'hAD60, 2, 1, 1, 5);
        repeat (5) @(posedge clk);
        #1;
        chk("shift_bit_idx", bit_idx, 5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignored_start_idx", bit_idx, 6);
        @(posedge clk); #1;
        chk("ignored_start_idx2", bit_idx, 7);
        chk("ignored_start_busy", busy, 1);
        finish_run();

        // Reset asserted mid-run at bit 7.
        launch(16'hAC00, 1, 1, 1, 5);
        n = 0;
        while (bit_idx != 4'd7 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_bit7", bit_idx, 7);
        void'(sb.pop_back());
        reset = 1'b0;
        #1;
        chk("mid_rst_det_clr_n", det_clr_n, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_bit_idx", bit_idx, 0);
        chk("mid_rst_match_cnt", match_cnt, 0);
        chk("mid_rst_ser_out", ser_out, 0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_done", done, 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_det_clr_n", det_clr_n, 1);
        @(posedge clk); #1;
        chk("post_rst_idle", busy, 0);

        // Back-to-back runs with start held high: one idle cycle between runs.
        @(posedge clk); #1;
        data_in = 16'hAC00;
        start   = 1'b1;
        c0      = cyc;
        push(1, 1, 1, 5, c0 + 18);
        push(1, 1, 1, 5, c0 + 18 + 19);
        push(1, 1, 1, 5, c0 + 18 + 38);
        repeat (2) begin
            wait_done();
            @(posedge clk); #1;
            chk("b2b_gap_busy", busy, 0);
            chk("b2b_gap_det_clr_n", det_clr_n, 1);
            @(posedge clk); #1;
            chk("b2b_restart_busy", busy, 1);
            chk("b2b_restart_det_clr_n", det_clr_n, 0);
        end
        start = 1'b0;
        finish_run();

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
